// File: rtl/sprite_dma_pkg.sv
// Shared types and constants for the sprite DMA engine.
// Optional feature macro: SPRITE_DMA_IRQ_EN (adds the irq output and CTRL irq_en/done-clear bits).
package sprite_dma_pkg;

  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned SPRITE_WORDS = 1024;
  localparam int unsigned PROG_WORDS   = 8192;
  localparam int unsigned SRC_BITS     = $clog2(PROG_WORDS);
  localparam int unsigned DST_BITS     = $clog2(SPRITE_WORDS);
  localparam int unsigned LEN_BITS     = DST_BITS + 1;

  localparam logic [ADDR_W-1:0] SPRITE_ADDR   = 16'h2000;
  localparam logic [ADDR_W-1:0] DMA_SRC_ADDR  = 16'h4804;
  localparam logic [ADDR_W-1:0] DMA_DST_ADDR  = 16'h4805;
  localparam logic [ADDR_W-1:0] DMA_LEN_ADDR  = 16'h4806;
  localparam logic [ADDR_W-1:0] DMA_CTRL_ADDR = 16'h4807;

  // CTRL write bits
  localparam int unsigned CTRL_START_BIT    = 0;
  localparam int unsigned CTRL_ABORT_BIT    = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT   = 3;
  localparam int unsigned CTRL_DONE_CLR_BIT = 4;

  // CTRL read bits
  localparam int unsigned STAT_BUSY_BIT   = 0;
  localparam int unsigned STAT_DONE_BIT   = 1;
  localparam int unsigned STAT_PAUSED_BIT = 2;
  localparam int unsigned STAT_IRQ_EN_BIT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BLANK,
    ST_READ,
    ST_CAPTURE,
    ST_WRITE
  } dma_state_e;

endpackage

// File: rtl/sprite_dma_regs.sv
// Register file for the sprite DMA: address decode, SRC/DST/LEN/CTRL, sticky done, readback.
// Optional feature macro: SPRITE_DMA_IRQ_EN.
module sprite_dma_regs
  import sprite_dma_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic                cpu_write,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic                busy,
  input  logic                paused,
  input  logic                done_set_c,
  output logic                start_c,
  output logic                abort_c,
  output logic [SRC_BITS-1:0] src_base,
  output logic [DST_BITS-1:0] dst,
  output logic [LEN_BITS-1:0] len,
  output logic [DATA_W-1:0]   reg_rdata
`ifdef SPRITE_DMA_IRQ_EN
  ,output logic               irq
`endif
);

  logic [DATA_W-1:0] src_q;
  logic              done_q;
  logic              done_d;
  logic              wr_src_c;
  logic              wr_dst_c;
  logic              wr_len_c;
  logic              wr_ctrl_c;
  logic [DATA_W-1:0] status_c;
  logic [DATA_W-1:0] rd_mux_c;
`ifdef SPRITE_DMA_IRQ_EN
  logic              irq_en_q;
  logic              irq_en_d;
`endif

  assign wr_src_c  = cpu_write && (cpu_addr == DMA_SRC_ADDR);
  assign wr_dst_c  = cpu_write && (cpu_addr == DMA_DST_ADDR);
  assign wr_len_c  = cpu_write && (cpu_addr == DMA_LEN_ADDR);
  assign wr_ctrl_c = cpu_write && (cpu_addr == DMA_CTRL_ADDR);

  // Abort beats a simultaneous start; a start while busy is dropped.
  assign abort_c = wr_ctrl_c && cpu_wdata[CTRL_ABORT_BIT];
  assign start_c = wr_ctrl_c && cpu_wdata[CTRL_START_BIT] && !cpu_wdata[CTRL_ABORT_BIT] && !busy;

  assign src_base = src_q[SRC_BITS-1:0];

  // Sticky done: start (or done-clear) clears it, completion sets it and wins.
  always_comb begin
    done_d = done_q;
    if (start_c) done_d = 1'b0;
`ifdef SPRITE_DMA_IRQ_EN
    if (wr_ctrl_c && cpu_wdata[CTRL_DONE_CLR_BIT]) done_d = 1'b0;
`endif
    if (done_set_c) done_d = 1'b1;
  end

`ifdef SPRITE_DMA_IRQ_EN
  // irq_en follows every CTRL write, busy or not.
  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_ctrl_c) irq_en_d = cpu_wdata[CTRL_IRQ_EN_BIT];
  end
`endif

  // Status word and readback selection.
  always_comb begin
    status_c                  = '0;
    status_c[STAT_BUSY_BIT]   = busy;
    status_c[STAT_DONE_BIT]   = done_q;
    status_c[STAT_PAUSED_BIT] = paused;
`ifdef SPRITE_DMA_IRQ_EN
    status_c[STAT_IRQ_EN_BIT] = irq_en_q;
`endif
    case (cpu_addr)
      DMA_SRC_ADDR:  rd_mux_c = src_q;
      DMA_DST_ADDR:  rd_mux_c = DATA_W'(dst);
      DMA_LEN_ADDR:  rd_mux_c = DATA_W'(len);
      DMA_CTRL_ADDR: rd_mux_c = status_c;
      default:       rd_mux_c = '0;
    endcase
  end

  // Register storage; transfer parameters are frozen while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q     <= '0;
      dst       <= '0;
      len       <= '0;
      done_q    <= 1'b0;
      reg_rdata <= '0;
`ifdef SPRITE_DMA_IRQ_EN
      irq_en_q  <= 1'b0;
      irq       <= 1'b0;
`endif
    end else begin
      if (wr_src_c && !busy) src_q <= cpu_wdata;
      if (wr_dst_c && !busy) dst   <= cpu_wdata[DST_BITS-1:0];
      if (wr_len_c && !busy) len   <= cpu_wdata[LEN_BITS-1:0];
      done_q    <= done_d;
      reg_rdata <= rd_mux_c;
`ifdef SPRITE_DMA_IRQ_EN
      irq_en_q  <= irq_en_d;
      irq       <= done_d && irq_en_d;
`endif
    end
  end

endmodule

// File: rtl/sprite_dma_controller.sv
// Sprite DMA engine: copies program-memory words into sprite RAM during vertical blank.
// Optional feature macro: SPRITE_DMA_IRQ_EN (adds irq output).
module sprite_dma_controller
  import sprite_dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] reg_rdata,
  input  logic              vbright,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_grant,
  output logic              busy
`ifdef SPRITE_DMA_IRQ_EN
  ,output logic             irq
`endif
);

  dma_state_e          state;
  dma_state_e          state_d;
  logic [LEN_BITS-1:0] idx;
  logic [LEN_BITS-1:0] idx_d;
  logic                paused;
  logic                start_c;
  logic                abort_c;
  logic                done_set_c;
  logic [SRC_BITS-1:0] src_base;
  logic [DST_BITS-1:0] dst;
  logic [LEN_BITS-1:0] len;
  logic [SRC_BITS-1:0] src_word_c;
  logic [DST_BITS-1:0] dst_word_c;
  logic [ADDR_W-1:0]   addr_d_c;

  sprite_dma_regs u_regs (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_write  (cpu_write),
    .cpu_wdata  (cpu_wdata),
    .busy       (busy),
    .paused     (paused),
    .done_set_c (done_set_c),
    .start_c    (start_c),
    .abort_c    (abort_c),
    .src_base   (src_base),
    .dst        (dst),
    .len        (len),
    .reg_rdata  (reg_rdata)
`ifdef SPRITE_DMA_IRQ_EN
    ,.irq       (irq)
`endif
  );

  // Next-state logic; pauses and aborts only take effect at word boundaries or before a write.
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    done_set_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_c) begin
          idx_d = '0;
          if (len == '0) done_set_c = 1'b1;
          else           state_d    = ST_WAIT_BLANK;
        end
      end
      ST_WAIT_BLANK: begin
        if (abort_c)       state_d = ST_IDLE;
        else if (!vbright) state_d = ST_READ;
      end
      ST_READ: begin
        state_d = abort_c ? ST_IDLE : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = abort_c ? ST_IDLE : ST_WRITE;
      end
      ST_WRITE: begin
        idx_d = LEN_BITS'(idx + 1'b1);
        if (abort_c) begin
          state_d = ST_IDLE;
        end else if (idx_d == len) begin
          state_d    = ST_IDLE;
          done_set_c = 1'b1;
        end else if (vbright) begin
          state_d = ST_WAIT_BLANK;
        end else begin
          state_d = ST_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Source wraps within program memory, destination within sprite RAM.
  always_comb begin
    src_word_c = SRC_BITS'(src_base + SRC_BITS'(idx_d));
    dst_word_c = DST_BITS'(dst + DST_BITS'(idx_d));
    case (state_d)
      ST_READ, ST_CAPTURE: addr_d_c = ADDR_W'(src_word_c);
      ST_WRITE:            addr_d_c = SPRITE_ADDR + ADDR_W'(dst_word_c);
      default:             addr_d_c = '0;
    endcase
  end

  // State register and registered bus/status outputs aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      paused    <= 1'b0;
      bus_grant <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      busy      <= (state_d != ST_IDLE);
      paused    <= (state_d == ST_WAIT_BLANK) && (idx_d != '0);
      bus_grant <= (state_d inside {ST_READ, ST_CAPTURE, ST_WRITE});
      mem_write <= (state_d == ST_WRITE);
      mem_addr  <= addr_d_c;
      mem_wdata <= (state_d == ST_WRITE) ? mem_rdata : '0;
    end
  end

endmodule
